// File: rtl/data_memory_arbiter_pkg.sv
// Shared defaults and FSM encoding for the two-master data memory arbiter.
package data_memory_arbiter_pkg;

    localparam int DEF_ADDR_W = 12;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

endpackage

// File: rtl/data_memory_arbiter_if.sv
// Bus bundle between the two masters, the arbiter and data_memory.
interface data_memory_arbiter_if #(
    parameter int ADDR_W = data_memory_arbiter_pkg::DEF_ADDR_W,
    parameter int DATA_W = data_memory_arbiter_pkg::DEF_DATA_W
);
    logic              m0_req, m0_lock, m0_wren, m0_gnt, m0_rvalid;
    logic [ADDR_W-1:0] m0_addr;
    logic [3:0]        m0_byteena;
    logic [DATA_W-1:0] m0_wdata, m0_rdata;

    logic              m1_req, m1_lock, m1_wren, m1_gnt, m1_rvalid;
    logic [ADDR_W-1:0] m1_addr;
    logic [3:0]        m1_byteena;
    logic [DATA_W-1:0] m1_wdata, m1_rdata;

    logic [ADDR_W-1:0] mem_address;
    logic [3:0]        mem_byteena;
    logic [DATA_W-1:0] mem_data, mem_q;
    logic              mem_wren;

    modport slave (
        input  m0_req, m0_lock, m0_addr, m0_byteena, m0_wdata, m0_wren,
        input  m1_req, m1_lock, m1_addr, m1_byteena, m1_wdata, m1_wren,
        input  mem_q,
        output m0_gnt, m0_rvalid, m0_rdata, m1_gnt, m1_rvalid, m1_rdata,
        output mem_address, mem_byteena, mem_data, mem_wren
    );

    modport master (
        output m0_req, m0_lock, m0_addr, m0_byteena, m0_wdata, m0_wren,
        output m1_req, m1_lock, m1_addr, m1_byteena, m1_wdata, m1_wren,
        output mem_q,
        input  m0_gnt, m0_rvalid, m0_rdata, m1_gnt, m1_rvalid, m1_rdata,
        input  mem_address, mem_byteena, mem_data, mem_wren
    );
endinterface

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: on a collision the master that did not win last time wins.
module rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic last_winner,
    output logic gnt0,
    output logic gnt1
);
    assign gnt0 = req0 & (~req1 | last_winner);
    assign gnt1 = req1 & (~req0 | ~last_winner);
endmodule

// File: rtl/data_memory_arbiter.sv
// Two-master arbiter in front of data_memory with bounded lock ownership and
// one-cycle read response routing.
module data_memory_arbiter
    import data_memory_arbiter_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int LOCK_MAX = 15
) (
    input  logic                  clock,
    input  logic                  reset,
    data_memory_arbiter_if.slave  bus
);
    localparam int              CNT_W   = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);

    arb_state_e       state, state_nxt;
    logic             last_winner, last_winner_nxt;
    logic [CNT_W-1:0] lock_cnt, lock_cnt_nxt;
    logic [1:0]       req, lock, wren, rr_gnt, gnt, rvalid;
    logic             owned;

    logic [ADDR_W-1:0] addr_sel;
    logic [DATA_W-1:0] wdata_sel, rdata;

    assign req  = {bus.m1_req,  bus.m0_req};
    assign lock = {bus.m1_lock, bus.m0_lock};
    assign wren = {bus.m1_wren, bus.m0_wren};

    rr_pick2 u_pick (
        .req0        (req[0]),
        .req1        (req[1]),
        .last_winner (last_winner),
        .gnt0        (rr_gnt[0]),
        .gnt1        (rr_gnt[1])
    );

    always_comb begin
        state_nxt    = state;
        lock_cnt_nxt = lock_cnt;
        gnt          = 2'b00;
        owned        = 1'b0;
        case (state)
            OWN0:    owned = req[0] & lock[0];
            OWN1:    owned = req[1] & lock[1];
            default: owned = 1'b0;
        endcase
        if (owned) begin
            gnt = (state == OWN1) ? 2'b10 : 2'b01;
            if (lock_cnt < CNT_MAX)
                lock_cnt_nxt = lock_cnt + 1'b1;
            // Ownership expires once the budget is used; the other master then wins IDLE.
            if (lock_cnt_nxt == CNT_MAX)
                state_nxt = IDLE;
        end else begin
            // Owner released (or no owner): free arbitration in this same cycle.
            gnt       = rr_gnt;
            state_nxt = IDLE;
            if (|(rr_gnt & lock)) begin
                lock_cnt_nxt = CNT_W'(1);
                if (CNT_MAX > CNT_W'(1))
                    state_nxt = rr_gnt[1] ? OWN1 : OWN0;
            end
        end
        if (!reset)
            gnt = 2'b00;
        last_winner_nxt = gnt[1] ? 1'b1 : (gnt[0] ? 1'b0 : last_winner);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            last_winner <= 1'b1;
            lock_cnt    <= '0;
            rvalid      <= 2'b00;
        end else begin
            state       <= state_nxt;
            last_winner <= last_winner_nxt;
            lock_cnt    <= lock_cnt_nxt;
            rvalid      <= gnt & req & ~wren;
        end
    end

    assign addr_sel        = gnt[1] ? bus.m1_addr  : bus.m0_addr;
    assign wdata_sel       = gnt[1] ? bus.m1_wdata : bus.m0_wdata;
    assign bus.mem_address = addr_sel;
    assign bus.mem_data    = wdata_sel;
    assign bus.mem_byteena = gnt[1] ? bus.m1_byteena : bus.m0_byteena;
    assign bus.mem_wren    = |(gnt & wren);

    assign bus.m0_gnt    = gnt[0];
    assign bus.m1_gnt    = gnt[1];
    assign bus.m0_rvalid = rvalid[0];
    assign bus.m1_rvalid = rvalid[1];
    assign rdata         = bus.mem_q;
    assign bus.m0_rdata  = rdata;
    assign bus.m1_rdata  = rdata;

endmodule
